// File: rtl/multi_key_debounce.sv
// N-channel push-button debouncer: 2-flop sync, shared heartbeat tick, per-channel
// stability counters, press/release pulses, optional one-hot qualification and auto-repeat.
`timescale 1ns/1ps
module multi_key_debounce #(
    parameter int N_KEYS       = 5,
    parameter int HB_WIDTH     = 21,
    parameter int STABLE_TICKS = 3,
    parameter int ONE_HOT      = 1,
    parameter int REPEAT_DELAY = 16,
    parameter int REPEAT_RATE  = 4,
    localparam int KC_W        = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] keys_in,
    input  logic              repeat_en,
    output logic [N_KEYS-1:0] level,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [KC_W-1:0]   key_code,
    output logic              key_valid,
    output logic              conflict
);

    localparam int SC_W = $clog2(STABLE_TICKS + 1);
    localparam int HC_W = $clog2(REPEAT_DELAY + 1);

    logic [N_KEYS-1:0]            sync_p0;
    logic [N_KEYS-1:0]            sync_p1;
    logic [HB_WIDTH-1:0]          hb_cnt;
    logic                         tick;
    logic [N_KEYS-1:0]            qual;
    logic [N_KEYS-1:0][SC_W-1:0]  stab_cnt;
    logic [N_KEYS-1:0][SC_W-1:0]  stab_next;
    logic [N_KEYS-1:0][HC_W-1:0]  hold_cnt;
    logic [N_KEYS-1:0][HC_W-1:0]  hold_next;
    logic [N_KEYS-1:0]            level_next;
    logic [N_KEYS-1:0]            press_next;
    logic [N_KEYS-1:0]            release_next;

    function automatic logic multi_active(input logic [N_KEYS-1:0] v);
        int cnt;
        cnt = 0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (v[i]) cnt++;
        end
        return cnt >= 2;
    endfunction

    function automatic logic [KC_W-1:0] lowest_index(input logic [N_KEYS-1:0] v);
        logic [KC_W-1:0] idx;
        idx = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (v[i]) idx = KC_W'(i);
        end
        return idx;
    endfunction

    assign tick = &hb_cnt;

    // With exclusive qualification, any multi-key chord looks like "no key" to the debouncer.
    always_comb begin
        qual = sync_p1;
        if (ONE_HOT != 0 && multi_active(sync_p1)) qual = '0;
    end

    always_comb begin
        level_next   = level;
        press_next   = '0;
        release_next = '0;
        stab_next    = stab_cnt;
        hold_next    = hold_cnt;
        for (int i = 0; i < N_KEYS; i++) begin
            if (tick) begin
                if (qual[i] == level[i]) begin
                    stab_next[i] = '0;
                end else if (stab_cnt[i] == SC_W'(STABLE_TICKS - 1)) begin
                    stab_next[i]    = '0;
                    level_next[i]   = ~level[i];
                    press_next[i]   = ~level[i];
                    release_next[i] = level[i];
                end else begin
                    stab_next[i] = stab_cnt[i] + SC_W'(1);
                end
            end
            // A release on the same tick wins over a repeat: the hold count just clears.
            if (!repeat_en || !level[i]) begin
                hold_next[i] = '0;
            end else if (tick) begin
                if (!level_next[i]) begin
                    hold_next[i] = '0;
                end else if (hold_cnt[i] == HC_W'(REPEAT_DELAY - 1)) begin
                    hold_next[i]  = HC_W'(REPEAT_DELAY - REPEAT_RATE);
                    press_next[i] = 1'b1;
                end else begin
                    hold_next[i] = hold_cnt[i] + HC_W'(1);
                end
            end
        end
    end

    // Stage boundary: synchroniser, heartbeat, debounce state and registered outputs.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            sync_p0       <= '0;
            sync_p1       <= '0;
            hb_cnt        <= '0;
            stab_cnt      <= '0;
            hold_cnt      <= '0;
            level         <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            key_code      <= '0;
            key_valid     <= 1'b0;
            conflict      <= 1'b0;
        end else begin
            sync_p0       <= keys_in;
            sync_p1       <= sync_p0;
            hb_cnt        <= hb_cnt + HB_WIDTH'(1);
            stab_cnt      <= stab_next;
            hold_cnt      <= hold_next;
            level         <= level_next;
            press_pulse   <= press_next;
            release_pulse <= release_next;
            key_code      <= lowest_index(level_next);
            key_valid     <= |level_next;
            conflict      <= (ONE_HOT != 0) && multi_active(sync_p1);
        end
    end

endmodule

// File: tb/tb_multi_key_debounce.sv
// Bench for multi_key_debounce with an 8-cycle heartbeat; pulses are matched against
// a queue of expected (cycle, press, release) events.
`timescale 1ns/1ps
module tb_multi_key_debounce;

    logic       sysclk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] keys_in = 5'b0;
    logic       repeat_en = 1'b0;
    logic [4:0] level;
    logic [4:0] press_pulse;
    logic [4:0] release_pulse;
    logic [2:0] key_code;
    logic       key_valid;
    logic       conflict;

    multi_key_debounce #(
        .N_KEYS(5), .HB_WIDTH(3), .STABLE_TICKS(3), .ONE_HOT(1),
        .REPEAT_DELAY(4), .REPEAT_RATE(2)
    ) dut (
        .sysclk(sysclk), .reset(reset), .keys_in(keys_in), .repeat_en(repeat_en),
        .level(level), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .key_code(key_code), .key_valid(key_valid), .conflict(conflict)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        int         cyc;
        logic [4:0] press;
        logic [4:0] rel;
    } ev_t;

    ev_t        exp_q[$];
    int         cyc = 0;
    logic [2:0] hbm = 3'd0;
    int         n_cmp = 0;
    int         n_fail = 0;
    bit         mon_en = 1'b0;

    // Reference heartbeat: the tick edge is the posedge following a cycle with hbm == 7.
    always @(posedge sysclk) begin
        cyc <= cyc + 1;
        hbm <= reset ? 3'd0 : hbm + 3'd1;
    end

    always @(negedge sysclk) begin
        ev_t e;
        if (mon_en) begin
            if (press_pulse != 5'b0 || release_pulse != 5'b0) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pulse cyc=%0d press=%b rel=%b (none expected)",
                             cyc, press_pulse, release_pulse);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.press !== press_pulse || e.rel !== release_pulse) begin
                        n_fail++;
                        $display("FAIL pulse got cyc=%0d press=%b rel=%b expected cyc=%0d press=%b rel=%b",
                                 cyc, press_pulse, release_pulse, e.cyc, e.press, e.rel);
                    end
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                n_cmp++;
                n_fail++;
                e = exp_q.pop_front();
                $display("FAIL missed_pulse expected cyc=%0d press=%b rel=%b, none by cyc=%0d",
                         e.cyc, e.press, e.rel, cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic push_ev(input int c, input logic [4:0] p, input logic [4:0] r);
        ev_t e;
        e.cyc = c;
        e.press = p;
        e.rel = r;
        exp_q.push_back(e);
    endtask

    // Ends at the negedge right after the next tick edge.
    task automatic step_to_tick();
        while (hbm != 3'd7) @(negedge sysclk);
        @(negedge sysclk);
    endtask

    task automatic step_ticks(input int n);
        for (int i = 0; i < n; i++) step_to_tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge sysclk);
        n_cmp++; if (level !== 5'b0) begin n_fail++; $display("FAIL reset_level got=%b exp=00000", level); end
        n_cmp++; if (press_pulse !== 5'b0) begin n_fail++; $display("FAIL reset_press got=%b exp=00000", press_pulse); end
        n_cmp++; if (release_pulse !== 5'b0) begin n_fail++; $display("FAIL reset_release got=%b exp=00000", release_pulse); end
        n_cmp++; if (key_code !== 3'd0) begin n_fail++; $display("FAIL reset_key_code got=%0d exp=0", key_code); end
        n_cmp++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_key_valid got=%b exp=0", key_valid); end
        n_cmp++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL reset_conflict got=%b exp=0", conflict); end
        reset = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_clean_press();
        step_to_tick();
        keys_in = 5'b00100;
        push_ev(cyc + 24, 5'b00100, 5'b0);
        step_ticks(2);
        n_cmp++; if (level !== 5'b0) begin n_fail++; $display("FAIL press_early_level got=%b exp=00000", level); end
        step_to_tick();
        n_cmp++; if (level !== 5'b00100) begin n_fail++; $display("FAIL press_level got=%b exp=00100", level); end
        n_cmp++; if (key_code !== 3'd2) begin n_fail++; $display("FAIL press_key_code got=%0d exp=2", key_code); end
        n_cmp++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL press_key_valid got=%b exp=1", key_valid); end
        step_ticks(6);
        n_cmp++; if (level !== 5'b00100) begin n_fail++; $display("FAIL hold_level got=%b exp=00100", level); end
    endtask

    task automatic test_release();
        keys_in = 5'b0;
        push_ev(cyc + 24, 5'b0, 5'b00100);
        step_ticks(2);
        n_cmp++; if (level !== 5'b00100) begin n_fail++; $display("FAIL release_early_level got=%b exp=00100", level); end
        step_to_tick();
        n_cmp++; if (level !== 5'b0) begin n_fail++; $display("FAIL release_level got=%b exp=00000", level); end
        n_cmp++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL release_key_valid got=%b exp=0", key_valid); end
        n_cmp++; if (key_code !== 3'd0) begin n_fail++; $display("FAIL release_key_code got=%0d exp=0", key_code); end
    endtask

    task automatic test_bounce();
        for (int t = 0; t < 12; t++) begin
            keys_in = {4'b0, ((t / 2) % 2 == 0)};
            step_to_tick();
            n_cmp++; if (level !== 5'b0) begin n_fail++; $display("FAIL bounce_level t=%0d got=%b exp=00000", t, level); end
        end
        keys_in = 5'b0;
        step_ticks(2);
    endtask

    task automatic test_conflict();
        keys_in = 5'b00010;
        push_ev(cyc + 24, 5'b00010, 5'b0);
        step_ticks(3);
        n_cmp++; if (level !== 5'b00010) begin n_fail++; $display("FAIL conflict_pre_level got=%b exp=00010", level); end
        keys_in = 5'b01010;
        push_ev(cyc + 24, 5'b0, 5'b00010);
        repeat (2) @(negedge sysclk);
        n_cmp++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL conflict_early got=%b exp=0", conflict); end
        @(negedge sysclk);
        n_cmp++; if (conflict !== 1'b1) begin n_fail++; $display("FAIL conflict_set got=%b exp=1", conflict); end
        step_ticks(3);
        n_cmp++; if (level !== 5'b0) begin n_fail++; $display("FAIL conflict_level got=%b exp=00000", level); end
        n_cmp++; if (conflict !== 1'b1) begin n_fail++; $display("FAIL conflict_held got=%b exp=1", conflict); end
        keys_in = 5'b01000;
        push_ev(cyc + 24, 5'b01000, 5'b0);
        repeat (3) @(negedge sysclk);
        n_cmp++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL conflict_clear got=%b exp=0", conflict); end
        step_ticks(3);
        n_cmp++; if (level !== 5'b01000) begin n_fail++; $display("FAIL conflict_key3_level got=%b exp=01000", level); end
        n_cmp++; if (key_code !== 3'd3) begin n_fail++; $display("FAIL conflict_key_code got=%0d exp=3", key_code); end
        keys_in = 5'b0;
        push_ev(cyc + 24, 5'b0, 5'b01000);
        step_ticks(3);
    endtask

    task automatic test_auto_repeat();
        int p;
        repeat_en = 1'b1;
        keys_in = 5'b10000;
        push_ev(cyc + 24, 5'b10000, 5'b0);
        step_ticks(3);
        n_cmp++; if (level !== 5'b10000) begin n_fail++; $display("FAIL repeat_level got=%b exp=10000", level); end
        n_cmp++; if (key_code !== 3'd4) begin n_fail++; $display("FAIL repeat_key_code got=%0d exp=4", key_code); end
        p = cyc;
        push_ev(p + 32, 5'b10000, 5'b0);
        push_ev(p + 48, 5'b10000, 5'b0);
        push_ev(p + 64, 5'b10000, 5'b0);
        step_ticks(8);
        repeat_en = 1'b0;
        step_ticks(4);
        repeat_en = 1'b1;
        push_ev(cyc + 32, 5'b10000, 5'b0);
        step_ticks(4);
        n_cmp++; if (level !== 5'b10000) begin n_fail++; $display("FAIL repeat_hold_level got=%b exp=10000", level); end
    endtask

    task automatic test_reset_mid_hold();
        reset = 1'b1;
        @(negedge sysclk);
        reset = 1'b0;
        repeat_en = 1'b0;
        n_cmp++; if (level !== 5'b0) begin n_fail++; $display("FAIL midreset_level got=%b exp=00000", level); end
        n_cmp++; if (press_pulse !== 5'b0) begin n_fail++; $display("FAIL midreset_press got=%b exp=00000", press_pulse); end
        n_cmp++; if (release_pulse !== 5'b0) begin n_fail++; $display("FAIL midreset_release got=%b exp=00000", release_pulse); end
        n_cmp++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_key_valid got=%b exp=0", key_valid); end
        n_cmp++; if (key_code !== 3'd0) begin n_fail++; $display("FAIL midreset_key_code got=%0d exp=0", key_code); end
        // Key still held: re-press lands on the third tick of the restarted heartbeat.
        push_ev(cyc + 24, 5'b10000, 5'b0);
        step_ticks(2);
        n_cmp++; if (level !== 5'b0) begin n_fail++; $display("FAIL midreset_early_level got=%b exp=00000", level); end
        step_to_tick();
        n_cmp++; if (level !== 5'b10000) begin n_fail++; $display("FAIL midreset_repress got=%b exp=10000", level); end
        keys_in = 5'b0;
        push_ev(cyc + 24, 5'b0, 5'b10000);
        step_ticks(3);
        n_cmp++; if (level !== 5'b0) begin n_fail++; $display("FAIL midreset_release_level got=%b exp=00000", level); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_release();
        test_bounce();
        test_conflict();
        test_auto_repeat();
        test_reset_mid_hold();
        repeat (10) @(negedge sysclk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_events got=%0d exp=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
